seq_div_32: RTL and testbench
=============================

# seq_div_32

Multi-cycle unsigned restoring divider, the subtractive counterpart to the adder/add-sub datapath: it computes quotient and remainder by repeated trial subtraction, one quotient bit per clock. It sits beside the ALU add/sub path and serves divide-class instructions that tolerate multi-cycle latency. A start/done handshake lets the control unit stall while the block is busy.

## Interface
- WIDTH, 32, operand/result width in bits (≥ 2)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled on rising clk in IDLE or DONE only
- dividend  input  WIDTH  numerator; captured on accepted start
- divisor  input  WIDTH  denominator; captured on accepted start
- busy  output  1  high while iterating (RUN state)
- done  output  1  one-cycle pulse; results valid from this cycle on
- quotient  output  WIDTH  unsigned quotient of the last completed operation
- remainder  output  WIDTH  unsigned remainder of the last completed operation
- div_by_zero  output  1  set with done when captured divisor was 0; held with results

## Operation
- Reset (async, rst_n=0): state IDLE; busy=0, done=0, div_by_zero=0, quotient=0, remainder=0; iteration counter=0.
- States: IDLE, RUN, DONE.
- IDLE/DONE + start=1: capture dividend into shift register Q and divisor into D; clear partial remainder R (WIDTH+1 bits internally).
  - divisor==0 → DONE next cycle; quotient=all ones, remainder=dividend, div_by_zero=1.
  - otherwise → RUN, counter=WIDTH-1, div_by_zero cleared.
- RUN, each cycle: {R,Q} shifted left by 1 (Q MSB into R LSB); trial T = R_shifted − {0,D} in WIDTH+1 bits; T non-negative (MSB 0) → R=T, Q LSB=1; else R unchanged (restore), Q LSB=0. Counter decrements; at counter==0 the iteration completes and state → DONE.
- DONE: done=1 for exactly one cycle; quotient=Q, remainder=R[WIDTH-1:0] registered at entry. Without start → IDLE; with start → accepted exactly as from IDLE (back-to-back).
- quotient/remainder/div_by_zero hold their values until the next done; they do not change during RUN.
- start while in RUN: ignored; operands not recaptured; no effect on in-flight result.
- Invariants at done (divisor≠0): dividend = quotient·divisor + remainder, remainder < divisor.
- All arithmetic unsigned; no overflow possible except divide-by-zero.

## Timing
- Start accepted on edge E0. Normal path: busy=1 during cycles after E0 through edge E0+WIDTH; done=1 in the cycle after edge E0+WIDTH (latency WIDTH cycles; 32 for default).
- Divide-by-zero: done=1 in the cycle after edge E0+1 (latency 1 cycle); busy never asserted.
- busy and done never high simultaneously.
- Throughput: one operation per WIDTH+1 cycles with back-to-back start in DONE.
- rst_n asserted mid-RUN: immediate abort to IDLE, all outputs to reset values, no done pulse; first start after rst_n deassertion behaves normally.
- Outputs are registered; no combinational path from inputs to outputs.

## Test plan
- 100 / 7 → after 32 cycles done=1 one cycle, quotient=14, remainder=2, div_by_zero=0; busy high exactly 32 cycles.
- 0xFFFFFFFF / 1 → quotient=0xFFFFFFFF, remainder=0; then 3 / 10 → quotient=0, remainder=3.
- 5 / 0 → done 1 cycle after start, quotient=0xFFFFFFFF, remainder=5, div_by_zero=1, busy never high; next 9/3 clears div_by_zero, quotient=3, remainder=0.
- Start 1000/9 then pulse start with 50/5 at cycle 10 of RUN → ignored; result quotient=111, remainder=1 at cycle 32.
- Back-to-back: assert start with 0x80000000/0x10 during the DONE cycle of a previous op → accepted; quotient=0x08000000, remainder=0 after 32 more cycles.
- rst_n low at cycle 15 of RUN → outputs all 0 asynchronously, no done; after release, 77/8 → quotient=9, remainder=5.

Source files
------------

// File: rtl/seq_div_32.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, start/done handshake.
// Quotient, remainder and div_by_zero are registered and hold until the next done pulse.
module seq_div_32 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    // ZERO is the single wait cycle of the divide-by-zero path before DONE.
    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE,
        ZERO
    } state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] d_reg;
    logic [WIDTH-1:0] r_reg;

    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   trial;
    logic             q_bit;
    logic [WIDTH-1:0] r_step;
    logic [WIDTH-1:0] q_step;

    // NOTE: every always_comb output gets a value on every path, so no latch can be inferred.
    always_comb begin
        r_shift = {r_reg, q_reg[WIDTH-1]};
        trial   = r_shift - {1'b0, d_reg};
        q_bit   = ~trial[WIDTH];
        r_step  = q_bit ? trial[WIDTH-1:0] : r_shift[WIDTH-1:0];
        q_step  = {q_reg[WIDTH-2:0], q_bit};
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            count       <= '0;
            q_reg       <= '0;
            d_reg       <= '0;
            r_reg       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    state <= IDLE;
                    if (start) begin
                        q_reg <= dividend;
                        d_reg <= divisor;
                        r_reg <= '0;
                        if (divisor == '0) begin
                            state <= ZERO;
                        end else begin
                            state       <= RUN;
                            busy        <= 1'b1;
                            count       <= CW'(WIDTH - 1);
                            div_by_zero <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    q_reg <= q_step;
                    r_reg <= r_step;
                    if (count == '0) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        quotient  <= q_step;
                        remainder <= r_step;
                    end else begin
                        count <= count - CW'(1);
                    end
                end
                ZERO: begin
                    state       <= DONE;
                    done        <= 1'b1;
                    quotient    <= '1;
                    remainder   <= q_reg;
                    div_by_zero <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_div_32.sv
// Scoreboard bench for seq_div_32: expected results queued at start, checked on done.
module tb_seq_div_32;

    localparam int W = 32;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        int           done_cycle;
        int           busy_cycles;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    exp_t         sb[$];
    int           n_checks = 0;
    int           n_pass   = 0;
    int           cycle    = 0;
    int           busy_cnt = 0;
    logic [W-1:0] hold_q   = '0;
    logic [W-1:0] hold_r   = '0;

    seq_div_32 #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cycle);
    endtask

    // Output monitor: handshake properties every cycle, scoreboard pop on done.
    always @(negedge clk) begin
        if (rst_n) begin
            check("busy_done_excl", 64'(busy & done), 64'd0);
            if (busy) begin
                busy_cnt++;
                check("q_hold_in_run", 64'(quotient), 64'(hold_q));
                check("r_hold_in_run", 64'(remainder), 64'(hold_r));
            end
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("quotient", 64'(quotient), 64'(e.q));
                    check("remainder", 64'(remainder), 64'(e.r));
                    check("div_by_zero", 64'(div_by_zero), 64'(e.dz));
                    check("latency", 64'(cycle), 64'(e.done_cycle));
                    check("busy_cycles", 64'(busy_cnt), 64'(e.busy_cycles));
                    hold_q = e.q;
                    hold_r = e.r;
                end
                busy_cnt = 0;
            end
        end
    end

    // Called at a negedge; drives start for one edge and records the expectation.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
        exp_t e;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (push) begin
            e.q           = (b == '0) ? '1 : a / b;
            e.r           = (b == '0) ? a : a % b;
            e.dz          = (b == '0);
            e.done_cycle  = cycle + ((b == '0) ? 1 : W);
            e.busy_cycles = (b == '0) ? 0 : W;
            sb.push_back(e);
        end
    endtask

    task automatic wait_done(input int limit);
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (done) return;
        end
        check("done_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_quotient", 64'(quotient), 64'd0);
        check("rst_remainder", 64'(remainder), 64'd0);
        check("rst_dz", 64'(div_by_zero), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(32'd100, 32'd7, 1'b1);
        wait_done(40);
        @(negedge clk);
        run_op(32'hFFFF_FFFF, 32'd1, 1'b1);
        wait_done(40);
        @(negedge clk);
        run_op(32'd3, 32'd10, 1'b1);
        wait_done(40);
        @(negedge clk);

        // Divide by zero, then a normal op that must clear the flag.
        run_op(32'd5, 32'd0, 1'b1);
        wait_done(5);
        @(negedge clk);
        run_op(32'd9, 32'd3, 1'b1);
        wait_done(40);
        @(negedge clk);

        // Start pulse during RUN must be ignored.
        run_op(32'd1000, 32'd9, 1'b1);
        repeat (9) @(negedge clk);
        dividend = 32'd50;
        divisor  = 32'd5;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(40);

        // Back-to-back start in the DONE cycle.
        run_op(32'h8000_0000, 32'h10, 1'b1);
        wait_done(40);
        @(negedge clk);

        // Asynchronous reset mid-RUN aborts without a done pulse.
        run_op(32'd1234, 32'd5, 1'b0);
        repeat (14) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_quotient", 64'(quotient), 64'd0);
        check("abort_remainder", 64'(remainder), 64'd0);
        check("abort_dz", 64'(div_by_zero), 64'd0);
        hold_q   = '0;
        hold_r   = '0;
        busy_cnt = 0;
        repeat (3) @(negedge clk);
        check("abort_no_done", 64'(done), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(32'd77, 32'd8, 1'b1);
        wait_done(40);

        // Random back-to-back chain, including the occasional small divisor.
        for (int i = 0; i < 4; i++) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            a = $urandom;
            b = (i[0]) ? W'($urandom_range(1, 300)) : W'($urandom);
            run_op(a, b, 1'b1);
            wait_done(40);
        end
        @(negedge clk);

        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
